serial_subtractor: RTL and testbench

SERIAL_SUBTRACTOR -- requirements
Module: serial_subtractor

---
 rtl/serial_arith_pkg.sv | 13 +
 rtl/full_subtractor.sv | 18 +
 rtl/serial_subtractor.sv | 135 +++++++++++++
 tb/tb_serial_subtractor.sv | 265 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/serial_arith_pkg.sv
// Shared types for the bit-serial arithmetic blocks.
// Latency: n/a (type definitions only).
// Backpressure: n/a.
package serial_arith_pkg;

  // Control states of a bit-serial operation.
  typedef enum logic [1:0] {
    IDLE = 2'd0,
    RUN  = 2'd1,
    DONE = 2'd2
  } state_t;

endpackage

// File: rtl/full_subtractor.sv
// One-bit full subtractor cell: diff = a - b - bin, borrow out on underflow.
// Latency: purely combinational.
// Backpressure: none.
module full_subtractor (
  input  logic a,
  input  logic b,
  input  logic bin,
  output logic diff,
  output logic bout
);

  // Borrow is generated when a=0,b=1, and propagated when a==b.
  always_comb begin
    diff = a ^ b ^ bin;
    bout = (~a & b) | (~(a ^ b) & bin);
  end

endmodule

// File: rtl/serial_subtractor.sv
// Bit-serial subtractor: diff = a - b - bin (mod 2^WIDTH), LSB first, one bit per cycle.
// Latency: WIDTH RUN cycles after the accepting edge; done pulses for one cycle in DONE.
// Backpressure: start is ignored while busy; optional ovf port under SERIAL_SUB_OVF_EN.
module serial_subtractor
  import serial_arith_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             bin,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] diff,
  output logic             bout
`ifdef SERIAL_SUB_OVF_EN
  ,
  output logic             ovf
`endif
);

  localparam int CW = $clog2(WIDTH + 1);

  state_t           r_state;
  state_t           w_state_nxt;
  logic [WIDTH-1:0] r_a;
  logic [WIDTH-1:0] r_b;
  logic [WIDTH-1:0] r_res;
  logic [WIDTH-1:0] r_diff;
  logic [CW-1:0]    r_cnt;
  logic             r_br;
  logic             r_bout;
  logic             w_accept;
  logic             w_last;
  logic             w_d;
  logic             w_bo;
  logic [WIDTH-1:0] w_res_nxt;

  // A new operation can only be taken when no bit is being processed.
  assign w_accept = start && (r_state != RUN);
  // Final RUN cycle: the MSB is being processed right now.
  assign w_last   = (r_state == RUN) && (r_cnt == CW'(WIDTH - 1));

  full_subtractor u_cell (
    .a    (r_a[0]),
    .b    (r_b[0]),
    .bin  (r_br),
    .diff (w_d),
    .bout (w_bo)
  );

  // New result bit enters at the top so the LSB ends up at bit 0 after WIDTH shifts.
  assign w_res_nxt = (r_res >> 1) | (WIDTH'(w_d) << (WIDTH - 1));

  // State register.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state <= IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next-state logic; DONE can chain straight into RUN for back-to-back work.
  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    w_state_nxt = start ? RUN : IDLE;
      RUN:     w_state_nxt = w_last ? DONE : RUN;
      DONE:    w_state_nxt = start ? RUN : IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // Moore outputs decoded from the state.
  always_comb begin
    busy = (r_state == RUN);
    done = (r_state == DONE);
  end

  // Operand capture on accept, then shift one bit per RUN cycle.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_a   <= '0;
      r_b   <= '0;
      r_res <= '0;
      r_br  <= 1'b0;
      r_cnt <= '0;
    end else if (w_accept) begin
      r_a   <= a;
      r_b   <= b;
      r_br  <= bin;
      r_cnt <= '0;
    end else if (r_state == RUN) begin
      r_a   <= r_a >> 1;
      r_b   <= r_b >> 1;
      r_br  <= w_bo;
      r_res <= w_res_nxt;
      r_cnt <= r_cnt + CW'(1);
    end
  end

  // Visible result only changes on completion, so partial sums are never exposed.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_diff <= '0;
      r_bout <= 1'b0;
    end else if (w_last) begin
      r_diff <= w_res_nxt;
      r_bout <= w_bo;
    end
  end

  assign diff = r_diff;
  assign bout = r_bout;

`ifdef SERIAL_SUB_OVF_EN
  logic r_ovf;

  // Signed overflow: borrow into the MSB differs from borrow out of it.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_ovf <= 1'b0;
    end else if (w_last) begin
      r_ovf <= r_br ^ w_bo;
    end
  end

  assign ovf = r_ovf;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor at WIDTH 8, 4 (exhaustive) and 1.
// Reference results come from plain integer arithmetic on the operands.
// Covers reset, latency, ignored start, mid-run reset and back-to-back operation.
module tb_serial_subtractor;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  logic       start8, bin8, busy8, done8, bout8;
  logic [7:0] a8, b8, diff8;
  logic       start4, bin4, busy4, done4, bout4;
  logic [3:0] a4, b4, diff4;
  logic       start1, bin1, busy1, done1, bout1;
  logic [0:0] a1, b1, diff1;
`ifdef SERIAL_SUB_OVF_EN
  logic       ovf8, ovf4, ovf1;
`endif

  int n_checks = 0;
  int n_fail   = 0;

  serial_subtractor #(.WIDTH(8)) u_dut8 (
    .clk(clk), .reset(reset), .start(start8), .a(a8), .b(b8), .bin(bin8),
    .busy(busy8), .done(done8), .diff(diff8), .bout(bout8)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf8)
`endif
  );

  serial_subtractor #(.WIDTH(4)) u_dut4 (
    .clk(clk), .reset(reset), .start(start4), .a(a4), .b(b4), .bin(bin4),
    .busy(busy4), .done(done4), .diff(diff4), .bout(bout4)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf4)
`endif
  );

  serial_subtractor #(.WIDTH(1)) u_dut1 (
    .clk(clk), .reset(reset), .start(start1), .a(a1), .b(b1), .bin(bin1),
    .busy(busy1), .done(done1), .diff(diff1), .bout(bout1)
`ifdef SERIAL_SUB_OVF_EN
    , .ovf(ovf1)
`endif
  );

  task automatic check_val(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  // Reference: unsigned wrap-around difference, unsigned borrow, signed range check.
  task automatic ref_sub(input int w, input longint ua, input longint ub, input longint ubin,
                         output longint d, output bit bo, output bit ov);
    longint full, half, sa, sb, sr;
    full = longint'(1) << w;
    half = full >> 1;
    d    = (ua - ub - ubin) & (full - 1);
    bo   = (ua < ub + ubin);
    sa   = (ua >= half) ? ua - full : ua;
    sb   = (ub >= half) ? ub - full : ub;
    sr   = sa - sb - ubin;
    ov   = (sr < -half) || (sr >= half);
  endtask

  // lat counts rising edges, the accepting edge being number 1.
  task automatic wait_done8(inout int lat);
    while (done8 !== 1'b1 && lat < 40) begin
      @(posedge clk); #1;
      lat++;
    end
  endtask

  task automatic check_result8(input string tag, input longint ed, input bit eb, input bit eo);
    check_val({tag, "_done"}, done8, 1'b1);
    check_val({tag, "_diff"}, diff8, ed);
    check_val({tag, "_bout"}, bout8, eb);
`ifdef SERIAL_SUB_OVF_EN
    check_val({tag, "_ovf"}, ovf8, eo);
`else
    if (eo) begin end
`endif
  endtask

  task automatic op8(input logic [7:0] ta, input logic [7:0] tbv, input logic tbin, input string tag);
    int lat;
    longint ed;
    bit eb, eo;
    ref_sub(8, ta, tbv, tbin, ed, eb, eo);
    @(negedge clk);
    a8 = ta; b8 = tbv; bin8 = tbin; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    check_val({tag, "_busy"}, busy8, 1'b1);
    wait_done8(lat);
    check_val({tag, "_lat"}, lat, 9);
    check_result8(tag, ed, eb, eo);
    @(posedge clk); #1;
    check_val({tag, "_pulse"}, done8, 1'b0);
    check_val({tag, "_hold"}, diff8, ed);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: time %0t, expected finish before 1000000", $time);
    $fatal(1, "watchdog expired");
  end

  initial begin
    int lat, seen;
    longint ed, ed2;
    bit eb, eo, eb2, eo2;

    reset = 1'b0;
    start8 = 1'b0; a8 = '0; b8 = '0; bin8 = 1'b0;
    start4 = 1'b0; a4 = '0; b4 = '0; bin4 = 1'b0;
    start1 = 1'b0; a1 = '0; b1 = '0; bin1 = 1'b0;

    #12;
    check_val("rst_busy", busy8, 1'b0);
    check_val("rst_done", done8, 1'b0);
    check_val("rst_diff", diff8, 8'h00);
    check_val("rst_bout", bout8, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    check_val("rst_ovf", ovf8, 1'b0);
`endif
    @(negedge clk);
    reset = 1'b1;

    // Directed cases.
    op8(8'h05, 8'h03, 1'b0, "d05m03");
    op8(8'h10, 8'h0F, 1'b1, "d10m0f_b");
    op8(8'h80, 8'h01, 1'b0, "d80m01");
    op8(8'h7F, 8'h01, 1'b0, "d7fm01");
    op8(8'hFF, 8'hFF, 1'b1, "dffmff_b");
    op8(8'h00, 8'h01, 1'b0, "d00m01");

    // Mid-run reset at RUN cycle 4: outputs (currently 0xFF / 1) clear at once.
    @(negedge clk);
    a8 = 8'h33; b8 = 8'h11; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    repeat (3) @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
    check_val("arst_busy", busy8, 1'b0);
    check_val("arst_done", done8, 1'b0);
    check_val("arst_diff", diff8, 8'h00);
    check_val("arst_bout", bout8, 1'b0);
`ifdef SERIAL_SUB_OVF_EN
    check_val("arst_ovf", ovf8, 1'b0);
`endif
    seen = 0;
    repeat (4) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) seen++;
    end
    @(negedge clk);
    reset = 1'b1;
    repeat (14) begin
      @(posedge clk); #1;
      if (done8 === 1'b1) seen++;
    end
    check_val("arst_no_done", seen, 0);
    op8(8'h33, 8'h11, 1'b0, "post_rst");

    // Start pulse with other operands during RUN must be ignored.
    @(negedge clk);
    a8 = 8'h05; b8 = 8'h03; bin8 = 1'b0; start8 = 1'b1;
    @(posedge clk); #1;
    start8 = 1'b0;
    lat = 1;
    repeat (2) begin
      @(posedge clk); #1;
      lat++;
    end
    a8 = 8'hAA; b8 = 8'h11; bin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    lat++;
    start8 = 1'b0;
    check_val("ign_busy", busy8, 1'b1);
    wait_done8(lat);
    check_val("ign_lat", lat, 9);
    check_result8("ign", 64'h02, 1'b0, 1'b0);
    @(posedge clk); #1;
    check_val("ign_idle", busy8, 1'b0);

    // Back-to-back: start held high through DONE.
    ref_sub(8, 8'hC8, 8'h37, 1, ed, eb, eo);
    ref_sub(8, 8'h12, 8'h34, 1, ed2, eb2, eo2);
    @(negedge clk);
    a8 = 8'hC8; b8 = 8'h37; bin8 = 1'b1; start8 = 1'b1;
    @(posedge clk); #1;
    lat = 1;
    a8 = 8'h12; b8 = 8'h34; bin8 = 1'b1;
    wait_done8(lat);
    check_val("b2b1_lat", lat, 9);
    check_result8("b2b1", ed, eb, eo);
    @(posedge clk); #1;
    lat = 1;
    start8 = 1'b0;
    check_val("b2b_nogap", busy8, 1'b1);
    wait_done8(lat);
    check_val("b2b2_lat", lat, 9);
    check_result8("b2b2", ed2, eb2, eo2);

    // Random operands.
    for (int i = 0; i < 24; i++) begin
      op8(8'($urandom_range(255, 0)), 8'($urandom_range(255, 0)), 1'($urandom_range(1, 0)), "rnd");
    end

    // Exhaustive WIDTH=4 sweep.
    for (int ia = 0; ia < 16; ia++) begin
      for (int ib = 0; ib < 16; ib++) begin
        for (int ic = 0; ic < 2; ic++) begin
          ref_sub(4, ia, ib, ic, ed, eb, eo);
          @(negedge clk);
          a4 = 4'(ia); b4 = 4'(ib); bin4 = 1'(ic); start4 = 1'b1;
          @(posedge clk); #1;
          start4 = 1'b0;
          lat = 1;
          while (done4 !== 1'b1 && lat < 20) begin
            @(posedge clk); #1;
            lat++;
          end
          check_val("w4_lat", lat, 5);
          check_val("w4_diff", diff4, ed);
          check_val("w4_bout", bout4, eb);
`ifdef SERIAL_SUB_OVF_EN
          check_val("w4_ovf", ovf4, eo);
`endif
        end
      end
    end

    // WIDTH=1: a single RUN cycle.
    for (int k = 0; k < 8; k++) begin
      ref_sub(1, (k >> 2) & 1, (k >> 1) & 1, k & 1, ed, eb, eo);
      @(negedge clk);
      a1 = 1'(k >> 2); b1 = 1'(k >> 1); bin1 = 1'(k); start1 = 1'b1;
      @(posedge clk); #1;
      start1 = 1'b0;
      lat = 1;
      while (done1 !== 1'b1 && lat < 10) begin
        @(posedge clk); #1;
        lat++;
      end
      check_val("w1_lat", lat, 2);
      check_val("w1_diff", diff1, ed);
      check_val("w1_bout", bout1, eb);
`ifdef SERIAL_SUB_OVF_EN
      check_val("w1_ovf", ovf1, eo);
`endif
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
